// File: rtl/auipc_alu_control_pkg.sv
// auipc_alu_control_pkg: opcodes, ALU op codes, next-PC select encodings and funct3 helpers.
package auipc_alu_control_pkg;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0, ALU_SUB  = 4'h1, ALU_SLL  = 4'h2, ALU_SLT  = 4'h3,
        ALU_SLTU = 4'h4, ALU_XOR  = 4'h5, ALU_SRL  = 4'h6, ALU_SRA  = 4'h7,
        ALU_OR   = 4'h8, ALU_AND  = 4'h9, ALU_BEQ  = 4'hA, ALU_BNE  = 4'hB,
        ALU_BLT  = 4'hC, ALU_BGE  = 4'hD, ALU_BLTU = 4'hE, ALU_BGEU = 4'hF
    } alu_op_e;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_JAL  = 2'b01;
    localparam logic [1:0] NPC_JALR = 2'b10;
    localparam logic [1:0] NPC_BR   = 2'b11;

    // SUB exists only for register-register ops; the immediate form ignores bit 30 there.
    function automatic alu_op_e alu_fn(input logic [2:0] f3, input logic b30, input logic is_r);
        case (f3)
            3'b000:  return (is_r && b30) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return b30 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic alu_op_e br_fn(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_BEQ;
            3'b001:  return ALU_BNE;
            3'b100:  return ALU_BLT;
            3'b101:  return ALU_BGE;
            3'b110:  return ALU_BLTU;
            3'b111:  return ALU_BGEU;
            default: return ALU_ADD;
        endcase
    endfunction
endpackage

// File: rtl/rv_alu.sv
// rv_alu: operand-B mux, RV32I arithmetic/logic and branch comparator.
module rv_alu
    import auipc_alu_control_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      sel_bit,
    input  logic            rs2_imm_sel,
    input  logic [XLEN-1:0] dataA,
    input  logic [XLEN-1:0] dataB,
    input  logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] alu_out,
    output logic            branch_taken
);
    logic [XLEN-1:0] b;
    logic [4:0]      sh;

    assign b  = rs2_imm_sel ? imm : dataB;
    assign sh = b[4:0];

    // Branch codes leave alu_out at zero and compare the raw register values.
    always_comb begin
        alu_out      = '0;
        branch_taken = 1'b0;
        case (alu_op_e'(sel_bit))
            ALU_ADD:  alu_out = dataA + b;
            ALU_SUB:  alu_out = dataA - b;
            ALU_SLL:  alu_out = dataA << sh;
            ALU_SLT:  alu_out = {{(XLEN-1){1'b0}}, $signed(dataA) < $signed(b)};
            ALU_SLTU: alu_out = {{(XLEN-1){1'b0}}, dataA < b};
            ALU_XOR:  alu_out = dataA ^ b;
            ALU_SRL:  alu_out = dataA >> sh;
            ALU_SRA:  alu_out = XLEN'($signed(dataA) >>> sh);
            ALU_OR:   alu_out = dataA | b;
            ALU_AND:  alu_out = dataA & b;
            ALU_BEQ:  branch_taken = dataA == dataB;
            ALU_BNE:  branch_taken = dataA != dataB;
            ALU_BLT:  branch_taken = $signed(dataA) < $signed(dataB);
            ALU_BGE:  branch_taken = $signed(dataA) >= $signed(dataB);
            ALU_BLTU: branch_taken = dataA < dataB;
            ALU_BGEU: branch_taken = dataA >= dataB;
            default:  ;
        endcase
    end
endmodule

// File: rtl/rv_ctrl_decode.sv
// rv_ctrl_decode: RV32I opcode/funct decode into ALU op, operand select and ungated enables.
module rv_ctrl_decode
    import auipc_alu_control_pkg::*;
(
    input  logic [31:0] instruction,
    output logic [3:0]  sel_bit,
    output logic        rs2_imm_sel,
    output logic        wenb,
    output logic        load_enb,
    output logic        jal,
    output logic        jalr,
    output logic        branch_enb,
    output logic        auipc_wenb,
    output logic        lui_enb,
    output logic [7:0]  strb
);
    logic [6:0] op;
    logic [2:0] f3;
    logic       b30;

    assign op  = instruction[6:0];
    assign f3  = instruction[14:12];
    assign b30 = instruction[30];

    // strb order: {sb, sh, sw, lb, lh, lw, lbu, lhu}
    always_comb begin
        sel_bit     = ALU_ADD;
        rs2_imm_sel = 1'b0;
        wenb        = 1'b0;
        load_enb    = 1'b0;
        jal         = 1'b0;
        jalr        = 1'b0;
        branch_enb  = 1'b0;
        auipc_wenb  = 1'b0;
        lui_enb     = 1'b0;
        strb        = 8'b0;
        case (op)
            OP_R: begin
                wenb    = 1'b1;
                sel_bit = alu_fn(f3, b30, 1'b1);
            end
            OP_I: begin
                wenb        = 1'b1;
                rs2_imm_sel = 1'b1;
                sel_bit     = alu_fn(f3, b30, 1'b0);
            end
            OP_LOAD: begin
                wenb        = 1'b1;
                rs2_imm_sel = 1'b1;
                load_enb    = 1'b1;
                strb        = f3 == 3'b000 ? 8'b0001_0000 :
                              f3 == 3'b001 ? 8'b0000_1000 :
                              f3 == 3'b010 ? 8'b0000_0100 :
                              f3 == 3'b100 ? 8'b0000_0010 :
                              f3 == 3'b101 ? 8'b0000_0001 : 8'b0;
            end
            OP_STORE: begin
                rs2_imm_sel = 1'b1;
                strb        = f3 == 3'b000 ? 8'b1000_0000 :
                              f3 == 3'b001 ? 8'b0100_0000 :
                              f3 == 3'b010 ? 8'b0010_0000 : 8'b0;
            end
            OP_BRANCH: begin
                branch_enb = 1'b1;
                sel_bit    = br_fn(f3);
            end
            OP_JAL: begin
                wenb = 1'b1;
                jal  = 1'b1;
            end
            OP_JALR: begin
                wenb        = 1'b1;
                jalr        = 1'b1;
                rs2_imm_sel = 1'b1;
            end
            OP_LUI: begin
                wenb    = 1'b1;
                lui_enb = 1'b1;
            end
            OP_AUIPC: begin
                wenb       = 1'b1;
                auipc_wenb = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/auipc_alu_control.sv
// auipc_alu_control: single-cycle RV32I decode/ALU/pc+imm slice; side-effect
// enables are held off until the first clock edge after reset is released.
module auipc_alu_control
    import auipc_alu_control_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] dataA,
    input  logic [XLEN-1:0] dataB,
    input  logic [XLEN-1:0] imm,
    output logic [3:0]      sel_bit,
    output logic [XLEN-1:0] alu_out,
    output logic            branch_taken,
    output logic [XLEN-1:0] pc_imm,
    output logic            rs2_imm_sel,
    output logic            wenb,
    output logic            load_enb,
    output logic            jal_enb,
    output logic            branch_enb,
    output logic            auipc_wenb,
    output logic            lui_enb,
    output logic            in_to_pr,
    output logic [1:0]      sel_bit_mux,
    output logic            sb,
    output logic            sh,
    output logic            sw,
    output logic            lb,
    output logic            lh,
    output logic            lw,
    output logic            lbu,
    output logic            lhu
);
    logic       active_q, active_d;
    logic       d_wenb, d_load, d_jal, d_jalr, d_branch, d_auipc, d_lui, taken;
    logic [7:0] d_strb;

    assign active_d = !rst;

    always_ff @(posedge clk) begin
        active_q <= active_d;
    end

    rv_ctrl_decode u_dec (
        .instruction (instruction),
        .sel_bit     (sel_bit),
        .rs2_imm_sel (rs2_imm_sel),
        .wenb        (d_wenb),
        .load_enb    (d_load),
        .jal         (d_jal),
        .jalr        (d_jalr),
        .branch_enb  (d_branch),
        .auipc_wenb  (d_auipc),
        .lui_enb     (d_lui),
        .strb        (d_strb)
    );

    rv_alu #(.XLEN(XLEN)) u_alu (
        .sel_bit      (sel_bit),
        .rs2_imm_sel  (rs2_imm_sel),
        .dataA        (dataA),
        .dataB        (dataB),
        .imm          (imm),
        .alu_out      (alu_out),
        .branch_taken (taken)
    );

    assign pc_imm       = pc + imm;
    assign wenb         = active_q & d_wenb;
    assign in_to_pr     = wenb;
    assign load_enb     = active_q & d_load;
    assign jal_enb      = active_q & (d_jal | d_jalr);
    assign branch_enb   = active_q & d_branch;
    assign auipc_wenb   = active_q & d_auipc;
    assign lui_enb      = active_q & d_lui;
    assign branch_taken = active_q & d_branch & taken;
    assign {sb, sh, sw, lb, lh, lw, lbu, lhu} = active_q ? d_strb : 8'b0;
    assign sel_bit_mux  = !active_q    ? NPC_PC4  :
                          d_jal        ? NPC_JAL  :
                          d_jalr       ? NPC_JALR :
                          branch_taken ? NPC_BR   : NPC_PC4;
endmodule

// File: tb/tb_auipc_alu_control.sv
// tb_auipc_alu_control: directed vector table plus reset-gating sequences.
module tb_auipc_alu_control;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction, pc, dataA, dataB, imm;
    logic [3:0]  sel_bit;
    logic [31:0] alu_out, pc_imm;
    logic        branch_taken, rs2_imm_sel, wenb, load_enb, jal_enb, branch_enb;
    logic        auipc_wenb, lui_enb, in_to_pr;
    logic [1:0]  sel_bit_mux;
    logic        sb, sh, sw, lb, lh, lw, lbu, lhu;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    auipc_alu_control #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .pc(pc), .dataA(dataA),
        .dataB(dataB), .imm(imm), .sel_bit(sel_bit), .alu_out(alu_out),
        .branch_taken(branch_taken), .pc_imm(pc_imm), .rs2_imm_sel(rs2_imm_sel),
        .wenb(wenb), .load_enb(load_enb), .jal_enb(jal_enb), .branch_enb(branch_enb),
        .auipc_wenb(auipc_wenb), .lui_enb(lui_enb), .in_to_pr(in_to_pr),
        .sel_bit_mux(sel_bit_mux), .sb(sb), .sh(sh), .sw(sw), .lb(lb), .lh(lh),
        .lw(lw), .lbu(lbu), .lhu(lhu)
    );

    typedef struct packed {
        logic [31:0] ins, pc, a, b, imm;
        logic [3:0]  sel;
        logic [31:0] alu, pci;
        logic        rs2, we, ld, jl, br, au, lu, tk;
        logic [1:0]  mx;
        logic [7:0]  st;
    } vec_t;

    vec_t v[21];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] im);
        instruction = i; pc = p; dataA = a; dataB = b; imm = im;
    endtask

    function automatic logic [22:0] ctrl_got();
        return {sel_bit, rs2_imm_sel, wenb, in_to_pr, load_enb, jal_enb, branch_enb,
                auipc_wenb, lui_enb, branch_taken, sel_bit_mux, sb, sh, sw, lb, lh, lw, lbu, lhu};
    endfunction

    initial begin
        //         ins           pc            a             b            imm           sel  alu           pc_imm        rs2 we ld jl br au lu tk mx     strobes
        v[0]  = '{32'h00500093, 32'h0,        32'h0,        32'h0,       32'h5,        4'h0, 32'h5,        32'h5,        1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,8'h00};
        v[1]  = '{32'h402081B3, 32'h0,        32'h3,        32'h5,       32'h0,        4'h1, 32'hFFFFFFFE, 32'h0,        1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,8'h00};
        v[2]  = '{32'h4020D1B3, 32'h0,        32'h80000000, 32'h4,       32'h0,        4'h7, 32'hF8000000, 32'h0,        1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,8'h00};
        v[3]  = '{32'h00208463, 32'h10,       32'h7,        32'h7,       32'h8,        4'hA, 32'h0,        32'h18,       1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,2'b11,8'h00};
        v[4]  = '{32'h00208463, 32'h10,       32'h7,        32'h6,       32'h8,        4'hA, 32'h0,        32'h18,       1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,8'h00};
        v[5]  = '{32'h00001297, 32'h20,       32'h0,        32'h0,       32'h1000,     4'h0, 32'h0,        32'h1020,     1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,8'h00};
        v[6]  = '{32'h0040A303, 32'h0,        32'h100,      32'h0,       32'h4,        4'h0, 32'h104,      32'h4,        1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,8'h04};
        v[7]  = '{32'h0060A223, 32'h0,        32'h100,      32'h0,       32'h4,        4'h0, 32'h104,      32'h4,        1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,8'h20};
        v[8]  = '{32'h010000EF, 32'h40,       32'h1,        32'h2,       32'h10,       4'h0, 32'h3,        32'h50,       1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,8'h00};
        v[9]  = '{32'h000080E7, 32'h0,        32'h200,      32'h0,       32'h8,        4'h0, 32'h208,      32'h8,        1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b10,8'h00};
        v[10] = '{32'h000010B7, 32'h0,        32'h5,        32'h6,       32'h1000,     4'h0, 32'hB,        32'h1000,     1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,8'h00};
        v[11] = '{32'hFFFFFFFF, 32'h0,        32'h3,        32'h4,       32'h9,        4'h0, 32'h7,        32'h9,        1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,8'h00};
        v[12] = '{32'h00000000, 32'hFFFFFFFC, 32'h0,        32'h0,       32'h8,        4'h0, 32'h0,        32'h4,        1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,8'h00};
        v[13] = '{32'h0020A1B3, 32'h0,        32'hFFFFFFFF, 32'h1,       32'h0,        4'h3, 32'h1,        32'h0,        1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,8'h00};
        v[14] = '{32'h0020B1B3, 32'h0,        32'hFFFFFFFF, 32'h1,       32'h0,        4'h4, 32'h0,        32'h0,        1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,8'h00};
        v[15] = '{32'h0020C463, 32'h10,       32'hFFFFFFFF, 32'h1,       32'h8,        4'hC, 32'h0,        32'h18,       1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,2'b11,8'h00};
        v[16] = '{32'h0020E463, 32'h10,       32'hFFFFFFFF, 32'h1,       32'h8,        4'hE, 32'h0,        32'h18,       1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,8'h00};
        v[17] = '{32'h4030D093, 32'h0,        32'h80000000, 32'h0,       32'h403,      4'h7, 32'hF0000000, 32'h403,      1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,8'h00};
        v[18] = '{32'h0040C303, 32'h0,        32'h100,      32'h0,       32'h4,        4'h0, 32'h104,      32'h4,        1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,8'h02};
        v[19] = '{32'h0040B303, 32'h0,        32'h100,      32'h0,       32'h4,        4'h0, 32'h104,      32'h4,        1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,8'h00};
        v[20] = '{32'h0020D463, 32'h10,       32'h5,        32'h5,       32'h8,        4'hD, 32'h0,        32'h18,       1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,2'b11,8'h00};

        rst = 1'b1;
        drive(32'h010000EF, 32'h40, 32'h0, 32'h0, 32'h10);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_jal_enb", {31'b0, jal_enb}, 32'h0);
        check("rst_wenb", {31'b0, wenb}, 32'h0);
        check("rst_mux", {30'b0, sel_bit_mux}, 32'h0);
        check("rst_pc_imm", pc_imm, 32'h50);
        rst = 1'b0;
        #1 check("pre_edge_jal_enb", {31'b0, jal_enb}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("post_rst_jal_enb", {31'b0, jal_enb}, 32'h1);
        check("post_rst_mux", {30'b0, sel_bit_mux}, 32'h1);
        check("post_rst_wenb", {31'b0, wenb}, 32'h1);

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            drive(v[i].ins, v[i].pc, v[i].a, v[i].b, v[i].imm);
            #1;
            check($sformatf("v%0d_ctrl", i), {9'b0, ctrl_got()},
                  {9'b0, v[i].sel, v[i].rs2, v[i].we, v[i].we, v[i].ld, v[i].jl, v[i].br,
                   v[i].au, v[i].lu, v[i].tk, v[i].mx, v[i].st});
            check($sformatf("v%0d_alu_out", i), alu_out, v[i].alu);
            check($sformatf("v%0d_pc_imm", i), pc_imm, v[i].pci);
        end

        @(negedge clk);
        drive(32'h00208463, 32'h10, 32'h7, 32'h7, 32'h8);
        rst = 1'b1;
        #1 check("mid_rst_pre_edge_taken", {31'b0, branch_taken}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_taken", {31'b0, branch_taken}, 32'h0);
        check("mid_rst_mux", {30'b0, sel_bit_mux}, 32'h0);
        check("mid_rst_branch_enb", {31'b0, branch_enb}, 32'h0);
        check("mid_rst_sel_bit", {28'b0, sel_bit}, 32'hA);
        check("mid_rst_pc_imm", pc_imm, 32'h18);
        drive(32'h0040A303, 32'h0, 32'h100, 32'h0, 32'h4);
        #1 check("mid_rst_lw", {31'b0, lw}, 32'h0);
        check("mid_rst_alu_out", alu_out, 32'h104);
        check("mid_rst_rs2_sel", {31'b0, rs2_imm_sel}, 32'h1);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("release_lw", {31'b0, lw}, 32'h1);
        check("release_load_enb", {31'b0, load_enb}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
